fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of pc_unit.
- Reads pc_out from pc_unit and sequences pc_unit via pc_op/en/pc_in.
- Fetches one 16-bit opcode word, plus an optional 16-bit immediate word, from instruction memory over a req/ack handshake.
- Presents the complete instruction to decode over a valid/ready handshake; accepts branch redirects from execute.

Parameters:
- IMM_BIT, 15: opcode bit that, when 1, marks a two-word instruction (immediate follows).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pc  input  16  current PC (pc_unit pc_out).
- pc_op  output  2  pc_unit operation; encodings are the `PC_NOP/`PC_INC/`PC_SET/`PC_RESET macros from cpu_constants.vh.
- pc_en  output  1  pc_unit enable; high exactly when pc_op != `PC_NOP.
- pc_set  output  16  pc_unit pc_in; equals branch_target.
- mem_req  output  1  instruction memory read request.
- mem_addr  output  16  registered read address; stable while mem_req is high.
- mem_ack  input  1  read complete; mem_rdata valid this cycle.
- mem_rdata  input  16  read data.
- instr_valid  output  1  instr/imm/instr_pc valid to decode.
- instr_ready  input  1  decode accepts the instruction.
- instr  output  16  opcode word.
- imm  output  16  immediate word; 0 for one-word instructions.
- instr_pc  output  16  address of the opcode word.
- branch_valid  input  1  single-cycle redirect request.
- branch_target  input  16  redirect address (word aligned).

Behaviour:
- Reset (rst=0, async): state=S_RESET. Register reset values: mem_addr=0, instr=0, imm=0, instr_pc=0, instr_valid=0, mem_req=0. While in S_RESET, pc_op=`PC_RESET and pc_en=1.
- Outputs are combinational from state: mem_req=1 in S_OP, S_IMM and S_DRAIN; instr_valid=1 only in S_OUT. pc_op=`PC_NOP unless stated below.
- S_RESET: one cycle after rst release, go to S_OP with mem_addr<=0.
- S_OP:
  - Hold mem_req/mem_addr until mem_ack.
  - On mem_ack: instr<=mem_rdata, instr_pc<=mem_addr, pc_op=`PC_INC.
  - If mem_rdata[IMM_BIT]=1: go to S_IMM, mem_addr<=mem_addr+2.
  - Else: imm<=0, go to S_OUT.
- S_IMM: on mem_ack, imm<=mem_rdata, pc_op=`PC_INC, go to S_OUT.
- S_OUT:
  - instr_valid=1; instr/imm/instr_pc held stable until accepted.
  - On instr_ready: go to S_OP with mem_addr<=pc. This costs one bubble cycle; no back-to-back valid.
- Redirect (branch_valid=1, any state except S_RESET): pc_op=`PC_SET, pc_set=branch_target. Takes priority over mem_ack, the `PC_INC it would cause, and instr_ready.
  - From S_OUT: the instruction is discarded even if instr_ready=1 that cycle (handshake does not count). Go to S_OP with mem_addr<=branch_target.
  - From S_OP or S_IMM with mem_ack=1 the same cycle: data discarded; go to S_OP with mem_addr<=branch_target.
  - From S_OP or S_IMM with mem_ack=0: the request cannot be aborted. Go to S_DRAIN; mem_addr and mem_req are held.
- S_DRAIN:
  - Hold request until mem_ack; discard data.
  - On ack: go to S_OP with mem_addr<=pc (the redirected PC).
  - A further branch_valid here issues `PC_SET and stays in S_DRAIN (last target wins).
- branch_valid during S_RESET is ignored.
- Arithmetic: mem_addr+2 is 16-bit modulo; 0xFFFE+2 wraps to 0x0000.
- Reset asserted mid-operation: immediate return to S_RESET; outstanding memory request dropped; instr_valid drops asynchronously.

Test Plan:
- Reset then sequential one-word fetch: mem holds 0x1234@0, 0x0042@2, ack 1 cycle after req. Required: first req at addr 0; instr=0x1234, imm=0, instr_pc=0, instr_valid; with ready held high, next req at addr 2; pc_op issues `PC_RESET once then `PC_INC per word.
- Two-word fetch: 0x8001@4, 0xBEEF@6. Required: reqs at 4 then 6; instr=0x8001, imm=0xBEEF, instr_pc=4; pc advances 4->8 via two `PC_INC.
- Decode stall: hold instr_ready=0 for 5 cycles in S_OUT. Required: instr_valid stays 1, outputs stable, no mem_req, pc_op=`PC_NOP throughout.
- Redirect during outstanding request: branch_valid with target 0x0100 while a req at 0x0010 is unacked; ack 3 cycles later with 0xDEAD. Required: `PC_SET that cycle; mem_addr stays 0x0010 until ack; 0xDEAD never appears as valid; next req at 0x0100.
- Redirect coincident with instr_ready in S_OUT, target 0x0200. Required: instruction dropped; instr_valid=0 next cycle; next req at 0x0200.
- Wrap and async reset: two-word opcode at 0xFFFE gives immediate req at 0x0000; rst=0 asserted mid-S_IMM gives mem_req=0 and instr_valid=0 immediately and pc_op=`PC_RESET.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives pc_unit and reads one- or two-word instructions
// from instruction memory, then presents them to decode.
`ifndef PC_NOP
`define PC_NOP   2'd0
`endif
`ifndef PC_INC
`define PC_INC   2'd1
`endif
`ifndef PC_SET
`define PC_SET   2'd2
`endif
`ifndef PC_RESET
`define PC_RESET 2'd3
`endif

module fetch_unit #(
    parameter int IMM_BIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic [1:0]  pc_op,
    output logic        pc_en,
    output logic [15:0] pc_set,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic [15:0] instr_pc,
    input  logic        branch_valid,
    input  logic [15:0] branch_target
);
    typedef enum logic [2:0] {
        S_RESET,
        S_OP,
        S_IMM,
        S_OUT,
        S_DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] imm_reg, imm_next;
    logic [15:0] instr_pc_reg, instr_pc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_RESET;
            mem_addr_reg <= '0;
            instr_reg    <= '0;
            imm_reg      <= '0;
            instr_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            instr_reg    <= instr_next;
            imm_reg      <= imm_next;
            instr_pc_reg <= instr_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        instr_next    = instr_reg;
        imm_next      = imm_reg;
        instr_pc_next = instr_pc_reg;
        pc_op         = `PC_NOP;
        mem_req       = 1'b0;
        instr_valid   = 1'b0;

        case (state_reg)
            S_RESET: begin
                pc_op         = `PC_RESET;
                state_next    = S_OP;
                mem_addr_next = '0;
            end
            S_OP, S_IMM: begin
                mem_req = 1'b1;
                if (branch_valid) begin
                    // An in-flight read cannot be aborted, so an unacked request is drained first.
                    pc_op = `PC_SET;
                    if (mem_ack) begin
                        state_next    = S_OP;
                        mem_addr_next = branch_target;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end else if (mem_ack) begin
                    pc_op = `PC_INC;
                    if (state_reg == S_OP) begin
                        instr_next    = mem_rdata;
                        instr_pc_next = mem_addr_reg;
                        if (mem_rdata[IMM_BIT]) begin
                            state_next    = S_IMM;
                            mem_addr_next = mem_addr_reg + 16'd2;
                        end else begin
                            imm_next   = '0;
                            state_next = S_OUT;
                        end
                    end else begin
                        imm_next   = mem_rdata;
                        state_next = S_OUT;
                    end
                end
            end
            S_OUT: begin
                instr_valid = 1'b1;
                if (branch_valid) begin
                    pc_op         = `PC_SET;
                    state_next    = S_OP;
                    mem_addr_next = branch_target;
                end else if (instr_ready) begin
                    state_next    = S_OP;
                    mem_addr_next = pc;
                end
            end
            S_DRAIN: begin
                mem_req = 1'b1;
                if (branch_valid) begin
                    pc_op = `PC_SET;
                end
                // pc_unit only sees a same-cycle redirect next cycle, so take the target directly.
                if (mem_ack) begin
                    state_next    = S_OP;
                    mem_addr_next = branch_valid ? branch_target : pc;
                end
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    assign pc_en    = (pc_op != `PC_NOP);
    assign pc_set   = branch_target;
    assign mem_addr = mem_addr_reg;
    assign instr    = instr_reg;
    assign imm      = imm_reg;
    assign instr_pc = instr_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every cycle
// against a transaction-level fetch model that also plays the roles of pc_unit and memory.
module tb_fetch_unit;
    localparam logic [1:0] OP_NOP = 2'd0, OP_INC = 2'd1, OP_SET = 2'd2, OP_RESET = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = '0;
    logic [1:0]  pc_op;
    logic        pc_en;
    logic [15:0] pc_set;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] instr_pc;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = '0;

    always #5 clk = ~clk;

    fetch_unit #(.IMM_BIT(15)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_op(pc_op), .pc_en(pc_en), .pc_set(pc_set),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .imm(imm),
        .instr_pc(instr_pc), .branch_valid(branch_valid), .branch_target(branch_target)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: reset phase, a presented instruction, a request to discard, waiting for an immediate.
    bit          m_in_reset;
    bit          m_have;
    bit          m_flush;
    bit          m_second;
    logic [15:0] m_addr, m_pc, m_instr, m_imm, m_ipc;

    logic [15:0] mem [logic [15:0]];
    int          wait_cnt = 0;
    int          lat = 1;
    int          lat_cfg = 1;
    bit          rand_lat = 1'b0;

    logic [15:0] acc_instr[$];
    logic [15:0] acc_imm[$];
    logic [15:0] acc_pc[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] w;
        if (!mem.exists(a)) begin
            w = 16'($urandom);
            w[15] = ($urandom_range(0, 2) == 0);
            mem[a] = w;
        end
        return mem[a];
    endfunction

    task automatic set_lat(input int v);
        lat_cfg = v;
        lat = v;
    endtask

    task automatic model_reset();
        m_in_reset = 1'b1;
        m_have     = 1'b0;
        m_flush    = 1'b0;
        m_second   = 1'b0;
        m_addr     = '0;
        wait_cnt   = 0;
    endtask

    task automatic drive_mem();
        if (rst && !m_in_reset && !m_have) begin
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_rd(m_addr);
                wait_cnt  = 0;
                lat       = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            wait_cnt  = 0;
        end
    endtask

    function automatic logic [1:0] exp_pc_op();
        if (m_in_reset) return OP_RESET;
        if (branch_valid) return OP_SET;
        if (!m_have && !m_flush && mem_ack) return OP_INC;
        return OP_NOP;
    endfunction

    task automatic compare();
        logic [1:0] eop;
        eop = exp_pc_op();
        check("pc_op", 16'(pc_op), 16'(eop));
        check("pc_en", 16'(pc_en), 16'(eop != OP_NOP));
        check("pc_set", pc_set, branch_target);
        check("mem_req", 16'(mem_req), 16'(!m_in_reset && !m_have));
        check("instr_valid", 16'(instr_valid), 16'(!m_in_reset && m_have));
        if (!m_in_reset && !m_have) check("mem_addr", mem_addr, m_addr);
        if (!m_in_reset && m_have) begin
            check("instr", instr, m_instr);
            check("imm", imm, m_imm);
            check("instr_pc", instr_pc, m_ipc);
        end
        if (rst && instr_valid && instr_ready && !branch_valid) begin
            acc_instr.push_back(instr);
            acc_imm.push_back(imm);
            acc_pc.push_back(instr_pc);
        end
    endtask

    task automatic model_step();
        logic [15:0] pc_now;
        pc_now = m_pc;
        if (!rst) begin
            model_reset();
            m_pc = '0;
        end else if (m_in_reset) begin
            m_in_reset = 1'b0;
            m_addr     = '0;
            m_pc       = '0;
        end else if (branch_valid) begin
            m_pc = branch_target;
            if (m_have || mem_ack) begin
                m_have   = 1'b0;
                m_flush  = 1'b0;
                m_second = 1'b0;
                m_addr   = branch_target;
            end else begin
                m_flush  = 1'b1;
                m_second = 1'b0;
            end
        end else if (m_have) begin
            if (instr_ready) begin
                m_have = 1'b0;
                m_addr = pc_now;
            end
        end else if (mem_ack) begin
            if (m_flush) begin
                m_flush = 1'b0;
                m_addr  = pc_now;
            end else begin
                m_pc = pc_now + 16'd2;
                if (!m_second) begin
                    m_instr = mem_rdata;
                    m_ipc   = m_addr;
                    if (mem_rdata[15]) begin
                        m_second = 1'b1;
                        m_addr   = m_addr + 16'd2;
                    end else begin
                        m_imm  = '0;
                        m_have = 1'b1;
                    end
                end else begin
                    m_imm    = mem_rdata;
                    m_second = 1'b0;
                    m_have   = 1'b1;
                end
            end
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic tick(input bit rdy, input bit bv, input logic [15:0] bt);
        pc            = m_pc;
        instr_ready   = rdy;
        branch_valid  = bv;
        branch_target = bt;
        drive_mem();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_instr_valid", 16'(instr_valid), 16'd0);
        check("rst_pc_op", 16'(pc_op), 16'(OP_RESET));
        check("rst_pc_en", 16'(pc_en), 16'd1);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_instr", instr, 16'h0000);
        check("rst_imm", imm, 16'h0000);
        check("rst_instr_pc", instr_pc, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b1, 16'h1234);
        rst = 1'b1;
        tick(1'b0, 1'b1, 16'h4444);
    endtask

    task automatic run_until_have();
        int n;
        n = 0;
        while (!m_have && n < 40) begin
            tick(1'b0, 1'b0, 16'h0000);
            n++;
        end
        vectors++;
        if (!m_have) begin
            miscompares++;
            $display("FAIL present_timeout: no instruction within 40 cycles at %0t", $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sz;
        bit rdy, bv;
        logic [15:0] bt;

        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'h0042;
        mem[16'h0004] = 16'h8001;
        mem[16'h0006] = 16'hBEEF;
        mem[16'h0008] = 16'h0001;
        mem[16'h0010] = 16'hDEAD;
        mem[16'h0100] = 16'h0777;
        mem[16'h0200] = 16'h0005;
        mem[16'hFFFE] = 16'h8123;
        set_lat(1);
        m_pc = '0;
        model_reset();

        @(posedge clk);
        #1;
        do_reset();
        check("first_req", 16'(mem_req), 16'd1);
        check("first_addr", mem_addr, 16'h0000);

        // Sequential one-word fetches with decode always ready
        n = 0;
        while (acc_instr.size() < 2 && n < 40) begin
            tick(1'b1, 1'b0, 16'h0000);
            n++;
        end
        check("accept_count", 16'(acc_instr.size()), 16'd2);
        if (acc_instr.size() >= 2) begin
            check("acc0_instr", acc_instr[0], 16'h1234);
            check("acc0_imm", acc_imm[0], 16'h0000);
            check("acc0_pc", acc_pc[0], 16'h0000);
            check("acc1_instr", acc_instr[1], 16'h0042);
            check("acc1_pc", acc_pc[1], 16'h0002);
        end
        check("seq_next_addr", mem_addr, 16'h0004);

        // Two-word instruction, then a five-cycle decode stall
        run_until_have();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 16'h0000);
            check("stall_valid", 16'(instr_valid), 16'd1);
            check("stall_req", 16'(mem_req), 16'd0);
            check("stall_pc_op", 16'(pc_op), 16'(OP_NOP));
            check("stall_instr", instr, 16'h8001);
            check("stall_imm", imm, 16'hBEEF);
            check("stall_instr_pc", instr_pc, 16'h0004);
        end
        tick(1'b1, 1'b0, 16'h0000);
        check("imm_next_addr", mem_addr, 16'h0008);

        // Redirect while a request is outstanding
        run_until_have();
        tick(1'b0, 1'b1, 16'h0010);
        set_lat(3);
        check("redir_addr", mem_addr, 16'h0010);
        tick(1'b0, 1'b1, 16'h0100);
        n = 0;
        while (m_flush && n < 10) begin
            check("drain_req", 16'(mem_req), 16'd1);
            check("drain_addr", mem_addr, 16'h0010);
            tick(1'b1, 1'b0, 16'h0000);
            n++;
        end
        check("after_drain_addr", mem_addr, 16'h0100);

        // Redirect coincident with instr_ready
        set_lat(1);
        run_until_have();
        sz = acc_instr.size();
        tick(1'b1, 1'b1, 16'h0200);
        check("drop_valid", 16'(instr_valid), 16'd0);
        check("drop_addr", mem_addr, 16'h0200);
        check("drop_no_accept", 16'(acc_instr.size()), 16'(sz));

        // Immediate address wraps past 0xFFFE, then reset lands mid-immediate
        run_until_have();
        tick(1'b0, 1'b1, 16'hFFFE);
        n = 0;
        while (!m_second && n < 10) begin
            tick(1'b0, 1'b0, 16'h0000);
            n++;
        end
        check("wrap_req", 16'(mem_req), 16'd1);
        check("wrap_addr", mem_addr, 16'h0000);
        set_lat(5);
        tick(1'b0, 1'b0, 16'h0000);
        do_reset();

        // Random traffic
        rand_lat = 1'b1;
        lat = int'($urandom_range(0, 3));
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 1) == 1);
            bv  = ($urandom_range(0, 15) == 0);
            bt  = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick(rdy, bv, bt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
